cm811_crc_comp: RTL and testbench



---
 rtl/cm811_init_pkg.sv | 26 ++
 rtl/cm811_crc16_word.sv | 26 ++
 rtl/cm811_crc_comp.sv | 161 ++++++++++++++++
 tb/tb_cm811_crc_comp.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cm811_init_pkg.sv
// Shared types and constants for the CM811 init sequence stages.
package cm811_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RUN,
        ST_CMP,
        ST_PASS,
        ST_FAIL
    } crc_state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CRC  = 2'd2;

    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // Travels alongside each RAM read so the returning word can be classified.
    typedef struct packed {
        logic vld;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/cm811_crc16_word.sv
// Combinational CRC-16 update over one 16-bit word, MSB first, non-reflected.
module cm811_crc16_word
    import cm811_init_pkg::*;
#(
    parameter logic [15:0] CRC_POLY = CRC16_POLY
) (
    input  logic [15:0] crc_in,
    input  logic [15:0] data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_acc;

    always_comb begin
        crc_acc = crc_in;
        for (int unsigned i = 0; i < 16; i++) begin
            if (crc_acc[15] ^ data_in[4'(15 - i)]) begin
                crc_acc = {crc_acc[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_acc = {crc_acc[14:0], 1'b0};
            end
        end
        crc_out = crc_acc;
    end

endmodule

// File: rtl/cm811_crc_comp.sv
// CRC compare stage: reads the loaded image back from RAM, recomputes its
// CRC-16 and checks it against the stored word, reporting a single result pulse.
module cm811_crc_comp
    import cm811_init_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned RD_LAT   = 1,
    parameter logic [15:0] CRC_INIT = CRC16_INIT,
    parameter logic [15:0] CRC_POLY = CRC16_POLY
) (
    input  logic              sys_clk,
    input  logic              glbl_rst,
    input  logic              comp_crc_en,
    output logic              comp_crc_done,
    output logic              comp_crc_error,
    output logic [1:0]        crc_err_code,
    output logic [15:0]       crc_calc,
    output logic              busy,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [15:0]       ram_rdata
);

    localparam logic [16:0] MAX_LEN      = 17'((32'd1 << ADDR_W) - 32'd2);
    localparam logic [2:0]  HDR_RUN_CNT  = 3'(RD_LAT + 2);
    localparam logic [2:0]  HDR_FAIL_CNT = 3'(RD_LAT + 3);

    crc_state_e        state;
    crc_state_e        state_nxt;
    logic [2:0]        hdr_cnt;
    logic [15:0]       len_q;
    logic              len_ok_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_addr;
    logic              iss_active;
    logic              issue_last;
    logic [15:0]       crc_q;
    logic [15:0]       crc_word;
    logic [15:0]       stored_q;
    rd_tag_t           tag_pipe [RD_LAT];
    rd_tag_t           ret_tag;

    assign ret_tag    = tag_pipe[RD_LAT-1];
    assign issue_last = (addr_q == last_addr);
    assign ram_addr   = addr_q;

    cm811_crc16_word #(
        .CRC_POLY(CRC_POLY)
    ) u_crc_word (
        .crc_in  (crc_q),
        .data_in (ram_rdata),
        .crc_out (crc_word)
    );

    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A bad length leaves HDR one cycle after a good one would, so both
    // outcomes keep their fixed, data-independent latency.
    always_comb begin
        state_nxt      = state;
        ram_rd_en      = 1'b0;
        busy           = 1'b0;
        comp_crc_done  = 1'b0;
        comp_crc_error = 1'b0;
        case (state)
            ST_IDLE: begin
                if (comp_crc_en) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                busy      = 1'b1;
                ram_rd_en = (hdr_cnt == 3'd0);
                if (hdr_cnt == HDR_RUN_CNT && len_ok_q) begin
                    state_nxt = ST_RUN;
                end else if (hdr_cnt == HDR_FAIL_CNT) begin
                    state_nxt = ST_FAIL;
                end
            end
            ST_RUN: begin
                busy      = 1'b1;
                ram_rd_en = iss_active;
                if (ret_tag.vld && ret_tag.last) state_nxt = ST_CMP;
            end
            ST_CMP: begin
                busy      = 1'b1;
                state_nxt = (crc_q == stored_q) ? ST_PASS : ST_FAIL;
            end
            ST_PASS: begin
                comp_crc_done = 1'b1;
                state_nxt     = ST_IDLE;
            end
            ST_FAIL: begin
                comp_crc_error = 1'b1;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            hdr_cnt      <= '0;
            len_q        <= '0;
            len_ok_q     <= 1'b0;
            addr_q       <= '0;
            last_addr    <= '0;
            iss_active   <= 1'b0;
            crc_q        <= '0;
            stored_q     <= '0;
            crc_calc     <= '0;
            crc_err_code <= ERR_NONE;
            for (int unsigned i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= '{vld: ram_rd_en, last: (state == ST_RUN) && issue_last};
            for (int unsigned i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

            case (state)
                ST_IDLE: begin
                    if (comp_crc_en) begin
                        hdr_cnt      <= '0;
                        addr_q       <= '0;
                        crc_q        <= CRC_INIT;
                        crc_err_code <= ERR_NONE;
                    end
                end
                ST_HDR: begin
                    hdr_cnt  <= hdr_cnt + 3'd1;
                    if (ret_tag.vld) len_q <= ram_rdata;
                    len_ok_q <= (len_q != 16'd0) && ({1'b0, len_q} <= MAX_LEN);
                    if (hdr_cnt == HDR_RUN_CNT && len_ok_q) begin
                        addr_q     <= ADDR_W'(1);
                        last_addr  <= ADDR_W'(len_q) + ADDR_W'(1);
                        iss_active <= 1'b1;
                    end
                    if (hdr_cnt == HDR_FAIL_CNT) crc_err_code <= ERR_LEN;
                end
                ST_RUN: begin
                    if (iss_active) begin
                        if (issue_last) iss_active <= 1'b0;
                        else            addr_q     <= addr_q + ADDR_W'(1);
                    end
                    if (ret_tag.vld) begin
                        if (ret_tag.last) stored_q <= ram_rdata;
                        else              crc_q    <= crc_word;
                    end
                end
                ST_CMP: begin
                    crc_calc <= crc_q;
                    if (crc_q != stored_q) crc_err_code <= ERR_CRC;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cm811_crc_comp.sv
// Directed bench for cm811_crc_comp: two instances (RD_LAT 1 and 3) with RAM models.
module tb_cm811_crc_comp;
    import cm811_init_pkg::*;

    localparam int unsigned AW = 10;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic          en_a = 1'b0, rst_a = 1'b1, done_a, err_a, busy_a, rd_en_a;
    logic [1:0]    code_a;
    logic [15:0]   crc_calc_a, rdata_a;
    logic [AW-1:0] addr_a;
    logic          en_b = 1'b0, rst_b = 1'b1, done_b, err_b, busy_b, rd_en_b;
    logic [1:0]    code_b;
    logic [15:0]   crc_calc_b, rdata_b;
    logic [AW-1:0] addr_b;

    cm811_crc_comp #(.ADDR_W(AW), .RD_LAT(1), .CRC_INIT(16'hFFFF), .CRC_POLY(16'h1021)) dut_a (
        .sys_clk(sys_clk), .glbl_rst(rst_a), .comp_crc_en(en_a),
        .comp_crc_done(done_a), .comp_crc_error(err_a), .crc_err_code(code_a),
        .crc_calc(crc_calc_a), .busy(busy_a), .ram_rd_en(rd_en_a),
        .ram_addr(addr_a), .ram_rdata(rdata_a));

    cm811_crc_comp #(.ADDR_W(AW), .RD_LAT(3), .CRC_INIT(16'hFFFF), .CRC_POLY(16'h1021)) dut_b (
        .sys_clk(sys_clk), .glbl_rst(rst_b), .comp_crc_en(en_b),
        .comp_crc_done(done_b), .comp_crc_error(err_b), .crc_err_code(code_b),
        .crc_calc(crc_calc_b), .busy(busy_b), .ram_rd_en(rd_en_b),
        .ram_addr(addr_b), .ram_rdata(rdata_b));

    // RAM models with 1 and 3 cycles of read latency
    logic [15:0] mem_a [1024];
    logic [15:0] mem_b [1024];
    logic [15:0] pipe_a;
    logic [15:0] pipe_b [3];
    always @(posedge sys_clk) pipe_a <= rd_en_a ? mem_a[addr_a] : 16'hxxxx;
    always @(posedge sys_clk) begin
        pipe_b[0] <= rd_en_b ? mem_b[addr_b] : 16'hxxxx;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rdata_a = pipe_a;
    assign rdata_b = pipe_b[2];

    typedef struct {
        bit          is_done;
        logic [1:0]  code;
        logic [15:0] crc;
        bit          chk_crc;
        int          lat;
        int          rd_cnt;
        int          burst;
        int          max_addr;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] img[$];
    int          addr_log[$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_byte(logic [15:0] c, logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    function automatic logic [15:0] golden(int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 1; i <= n; i++) c = crc_byte(crc_byte(c, img[i][15:8]), img[i][7:0]);
        return c;
    endfunction

    task automatic make_image(input int n, input logic [15:0] flip);
        img.delete();
        img.push_back(16'(n));
        for (int i = 0; i < n; i++) img.push_back(16'($urandom));
        img.push_back(golden(n) ^ flip);
    endtask

    task automatic load_image(input bit d);
        for (int i = 0; i < img.size(); i++) begin
            if (d) mem_b[i] = img[i];
            else   mem_a[i] = img[i];
        end
    endtask

    task automatic push_exp(input bit is_done, input logic [1:0] code, input logic [15:0] crc,
                            input bit chk_crc, input int lat, input int rd, input int burst,
                            input int maxa);
        exp_t e;
        e.is_done = is_done; e.code = code; e.crc = crc; e.chk_crc = chk_crc;
        e.lat = lat; e.rd_cnt = rd; e.burst = burst; e.max_addr = maxa;
        sb.push_back(e);
    endtask

    task automatic set_en(input bit d, input logic v);
        if (d) en_b = v;
        else   en_a = v;
    endtask

    task automatic do_run(input bit d, input int second_at, input bit en_on_pulse, input string name);
        int   lat, rd_cnt, cur, burst, max_addr, both;
        bit   seen;
        logic rden, dn, er, bsy, bsy_p;
        logic [1:0]  code;
        logic [15:0] crc;
        int   addr;
        exp_t e;
        addr_log.delete();
        lat = -1; rd_cnt = 0; cur = 0; burst = 0; max_addr = 0; both = 0; seen = 0;
        bsy_p = 1'bx; code = 2'bxx; crc = 16'hxxxx;
        @(negedge sys_clk); set_en(d, 1'b1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        for (int k = 0; k < 3000; k++) begin
            if (k > 0) @(negedge sys_clk);
            set_en(d, k == second_at);
            rden = d ? rd_en_b : rd_en_a;
            addr = d ? int'(addr_b) : int'(addr_a);
            dn   = d ? done_b : done_a;
            er   = d ? err_b : err_a;
            bsy  = d ? busy_b : busy_a;
            if (rden) begin
                rd_cnt++; cur++;
                if (cur > burst) burst = cur;
                if (addr > max_addr) max_addr = addr;
                addr_log.push_back(addr);
            end else begin
                cur = 0;
            end
            if (dn && er) both++;
            if (dn || er) begin
                seen = 1; lat = k; bsy_p = bsy;
                code = d ? code_b : code_a;
                crc  = d ? crc_calc_b : crc_calc_a;
                break;
            end
        end
        if (en_on_pulse) set_en(d, 1'b1);
        chk({name, ".pulse_seen"}, 32'(seen), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, ".done"}, 32'(dn), 32'(e.is_done));
            chk({name, ".error"}, 32'(er), 32'(!e.is_done));
            chk({name, ".both"}, both, 0);
            chk({name, ".latency"}, lat, e.lat);
            chk({name, ".err_code"}, 32'(code), 32'(e.code));
            if (e.chk_crc) chk({name, ".crc_calc"}, 32'(crc), 32'(e.crc));
            chk({name, ".rd_cnt"}, rd_cnt, e.rd_cnt);
            chk({name, ".rd_burst"}, burst, e.burst);
            chk({name, ".max_addr"}, max_addr, e.max_addr);
            chk({name, ".busy_at_pulse"}, 32'(bsy_p), 32'd0);
        end else begin
            chk({name, ".scoreboard_empty"}, 32'(sb.size()), 32'd1);
        end
        @(negedge sys_clk);
        set_en(d, 1'b0);
        chk({name, ".pulse_drop"}, 32'(d ? (done_b | err_b) : (done_a | err_a)), 32'd0);
        chk({name, ".busy_drop"}, 32'(d ? busy_b : busy_a), 32'd0);
    endtask

    task automatic quiet(input bit d, input int n, input string name);
        int pulses, bsy;
        pulses = 0; bsy = 0;
        repeat (n) begin
            @(negedge sys_clk);
            pulses += int'(d ? (done_b | err_b) : (done_a | err_a));
            bsy    += int'(d ? busy_b : busy_a);
        end
        chk({name, ".no_pulse"}, pulses, 0);
        chk({name, ".idle_busy"}, bsy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("reset_a", {done_a, err_a, code_a, crc_calc_a, busy_a, rd_en_a, addr_a}, 32'd0);
        chk("reset_b", {done_b, err_b, code_b, crc_calc_b, busy_b, rd_en_b, addr_b}, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge sys_clk);
        chk("idle_a", {done_a, err_a, code_a, crc_calc_a, busy_a, rd_en_a, addr_a}, 32'd0);

        // Known small image: CRC of one zero word
        img = '{16'h0001, 16'h0000, 16'h1D0F};
        load_image(0);
        push_exp(1, ERR_NONE, 16'h1D0F, 1, 8, 3, 2, 2);
        do_run(0, -1, 0, "a_good");
        for (int i = 0; i < 3; i++)
            chk($sformatf("a_good.addr%0d", i), (addr_log.size() > i) ? addr_log[i] : 32'hDEAD, i);

        mem_a[2] = 16'h1D0E;
        push_exp(0, ERR_CRC, 16'h1D0F, 1, 8, 3, 2, 2);
        do_run(0, -1, 0, "a_mismatch");

        mem_a[0] = 16'h0000;
        push_exp(0, ERR_LEN, 16'h0, 0, 5, 1, 1, 0);
        do_run(0, -1, 0, "a_len0");

        mem_a[0] = 16'h03FF;
        push_exp(0, ERR_LEN, 16'h0, 0, 5, 1, 1, 0);
        do_run(0, -1, 0, "a_len3ff");

        // Second start mid-RUN and a start during the result pulse are both ignored
        make_image(20, 16'h0000);
        load_image(0);
        push_exp(1, ERR_NONE, img[21], 1, 27, 22, 21, 21);
        do_run(0, 10, 1, "a_busy_start");
        quiet(0, 40, "a_after_busy");

        // Reset mid-RUN: everything clears, no pulse, in-flight data dropped
        @(negedge sys_clk); en_a = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk); en_a = 1'b0;
        repeat (9) @(negedge sys_clk);
        rst_a = 1'b1;
        @(negedge sys_clk);
        chk("a_midrst_outputs", {done_a, err_a, code_a, crc_calc_a, busy_a, rd_en_a, addr_a}, 32'd0);
        rst_a = 1'b0;
        quiet(0, 40, "a_after_rst");

        img = '{16'h0001, 16'h0000, 16'h1D0F};
        load_image(0);
        push_exp(1, ERR_NONE, 16'h1D0F, 1, 8, 3, 2, 2);
        do_run(0, -1, 0, "a_after_rst_pass");

        // RD_LAT=3 instance: long image, length boundaries
        make_image(1021, 16'h0000);
        load_image(1);
        push_exp(1, ERR_NONE, img[1022], 1, 1032, 1023, 1022, 1022);
        do_run(1, -1, 0, "b_long");

        make_image(1022, 16'h8000);
        load_image(1);
        push_exp(0, ERR_CRC, golden(1022), 1, 1033, 1024, 1023, 1023);
        do_run(1, -1, 0, "b_maxlen_mismatch");

        mem_b[0] = 16'h03FF;
        push_exp(0, ERR_LEN, 16'h0, 0, 7, 1, 1, 0);
        do_run(1, -1, 0, "b_len3ff");

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
